// File: rtl/shifter_unit_if.sv
// Operand/result bundle for the B-operand shifter: the producer drives the operand
// side and the shifter drives the registered result side.
interface shifter_unit_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in;
    logic [1:0]       shift;
    logic             in_valid;
    logic [WIDTH-1:0] sout;
    logic             out_valid;
    logic             shout;
    logic             zero;

    modport master (
        output in, shift, in_valid,
        input  sout, out_valid, shout, zero
    );

    modport slave (
        input  in, shift, in_valid,
        output sout, out_valid, shout, zero
    );
endinterface

// File: rtl/shifter_unit.sv
// One-bit pass/LSL/LSR/ASR shifter between the register-file B operand and the ALU.
// The result, shifted-out bit and zero flag are registered, so latency is one cycle.
module shifter_unit #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    shifter_unit_if.slave  bus
);
    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_LSL  = 2'b01;
    localparam logic [1:0] OP_LSR  = 2'b10;
    localparam logic [1:0] OP_ASR  = 2'b11;

    logic [WIDTH-1:0] r;
    logic             r_out;

    always_comb begin
        r     = bus.in;
        r_out = 1'b0;
        case (bus.shift)
            OP_PASS: begin
                r     = bus.in;
                r_out = 1'b0;
            end
            OP_LSL: begin
                r     = {bus.in[WIDTH-2:0], 1'b0};
                r_out = bus.in[WIDTH-1];
            end
            OP_LSR: begin
                r     = {1'b0, bus.in[WIDTH-1:1]};
                r_out = bus.in[0];
            end
            OP_ASR: begin
                r     = {bus.in[WIDTH-1], bus.in[WIDTH-1:1]};
                r_out = bus.in[0];
            end
            default: begin
                r     = bus.in;
                r_out = 1'b0;
            end
        endcase
    end

    // Reset wins over a simultaneous operand, which is therefore dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.sout      <= '0;
            bus.shout     <= 1'b0;
            bus.zero      <= 1'b1;
            bus.out_valid <= 1'b0;
        end else if (bus.in_valid) begin
            bus.sout      <= r;
            bus.shout     <= r_out;
            bus.zero      <= (r == '0);
            bus.out_valid <= 1'b1;
        end else begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_shifter_unit.sv
// Self-checking bench for shifter_unit: directed cases plus randomized operands,
// checked against an arithmetic model of the shift rules.
module tb_shifter_unit;
    localparam int WIDTH = 16;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    shifter_unit_if #(.WIDTH(WIDTH)) bus ();

    shifter_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: what the outputs should show after the last edge.
    int exp_sout;
    int exp_shout;
    int exp_zero;
    int exp_valid;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_res(input int x, input int op);
        case (op)
            0: return x;
            1: return (x * 2) % 65536;
            2: return x / 2;
            default: return x / 2 + ((x >= 32768) ? 32768 : 0);
        endcase
    endfunction

    function automatic int model_out(input int x, input int op);
        case (op)
            0: return 0;
            1: return x / 32768;
            default: return x % 2;
        endcase
    endfunction

    task automatic step(input int x, input int op, input bit vld, input bit rst, input string tag);
        @(negedge clk);
        bus.in       = x[WIDTH-1:0];
        bus.shift    = op[1:0];
        bus.in_valid = vld;
        reset        = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_sout = 0; exp_shout = 0; exp_zero = 1; exp_valid = 0;
        end else if (vld) begin
            exp_sout  = model_res(x, op);
            exp_shout = model_out(x, op);
            exp_zero  = (exp_sout == 0) ? 1 : 0;
            exp_valid = 1;
        end else begin
            exp_valid = 0;
        end
        chk({tag, ".sout"},      int'(bus.sout),      exp_sout);
        chk({tag, ".shout"},     int'(bus.shout),     exp_shout);
        chk({tag, ".zero"},      int'(bus.zero),      exp_zero);
        chk({tag, ".out_valid"}, int'(bus.out_valid), exp_valid);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.in = '0; bus.shift = '0; bus.in_valid = 1'b0;
        reset = 1'b1;
        exp_sout = 0; exp_shout = 0; exp_zero = 1; exp_valid = 0;

        step(16'h1234, 1, 1'b0, 1'b1, "rst0");
        step(16'h1234, 1, 1'b1, 1'b1, "rst1");

        // Constants from the worked examples, checked independently of the model.
        step(16'hF0CF, 0, 1'b1, 1'b0, "pass");
        chk("pass.lit", int'(bus.sout), 16'hF0CF);
        step(16'hF0CF, 1, 1'b1, 1'b0, "lsl");
        chk("lsl.lit", int'(bus.sout), 16'hE19E);
        step(16'hF0CF, 2, 1'b1, 1'b0, "lsr");
        chk("lsr.lit", int'(bus.sout), 16'h7867);
        step(16'hF0CF, 3, 1'b1, 1'b0, "asr");
        chk("asr.lit", int'(bus.sout), 16'hF867);

        step(16'h7FFE, 3, 1'b1, 1'b0, "asr_pos");
        chk("asr_pos.lit", int'(bus.sout), 16'h3FFF);
        step(16'h8000, 2, 1'b1, 1'b0, "lsr_msb");
        chk("lsr_msb.lit", int'(bus.sout), 16'h4000);
        step(16'h8000, 3, 1'b1, 1'b0, "asr_msb");
        chk("asr_msb.lit", int'(bus.sout), 16'hC000);

        step(16'h0001, 2, 1'b1, 1'b0, "lsr_zero");
        chk("lsr_zero.lit", int'(bus.zero), 1);
        step(16'h8000, 1, 1'b1, 1'b0, "lsl_zero");
        chk("lsl_zero.lit", int'(bus.shout), 1);

        step(16'h00A5, 1, 1'b1, 1'b0, "cap");
        step(16'hFFFF, 3, 1'b0, 1'b0, "hold");
        chk("hold.lit", int'(bus.sout), 16'h014A);

        for (int i = 0; i < 4; i++)
            step(16'h1111 * (i + 1), i, 1'b1, 1'b0, "b2b");

        step(16'hAAAA, 2, 1'b1, 1'b1, "rst_mid");
        step(16'h5555, 0, 1'b0, 1'b0, "post_rst");
        chk("post_rst.lit", int'(bus.out_valid), 0);
        step(16'h0003, 1, 1'b1, 1'b0, "first_cap");

        for (int i = 0; i < 300; i++) begin
            int x;
            x = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 7) == 0) x = ($urandom_range(0, 1) == 1) ? 32768 : 1;
            step(x, int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 29) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
